// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-access controller.
// The timeout counter width is derived from the timeout depth by a helper function.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Any set bit under this mask makes a word access misaligned.
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic int tmo_cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for the data memory.
// Flags expiry once TIMEOUT_CYCLES-1 has been reached.
module mem_timeout_counter
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign expired = (count_q == LAST);

    // Holds at the terminal value so the count can never wrap back to zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-access controller: req/ack handshake to data memory, pipeline
// stall while an access is outstanding, misalignment and timeout reporting.
//   state | meaning
//   IDLE  | no access outstanding; an aligned access stalls and issues a request
//   WAIT  | request held on the bus until ack or timeout
//   DONE  | access complete; pipeline advances at this edge
module mem_stage_access_unit
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_Valid,
    input  logic [ADDR_WIDTH-1:0] in_ALUResult,
    input  logic [DATA_WIDTH-1:0] in_WriteData,
    input  logic                  in_CtrlMemRead,
    input  logic                  in_CtrlMemWrite,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [DATA_WIDTH-1:0] out_MemoryData,
    output logic                  out_Stall,
    output logic                  out_Done,
    output logic                  out_MisalignedError,
    output logic                  out_TimeoutError
);

    state_e state_q, state_d;

    logic                  access;
    logic                  misaligned;
    logic                  start;
    logic                  expired;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  timeout_err_q;

    assign access     = in_Valid & (in_CtrlMemRead | in_CtrlMemWrite);
    assign misaligned = |(in_ALUResult[1:0] & WORD_ALIGN_MASK);
    assign start      = (state_q == IDLE) & access & ~misaligned;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .enable (state_q == WAIT),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WAIT;
            WAIT:    if (mem_ack || expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Input-dependent outputs are gated so reset clears them without waiting for an edge.
    always_comb begin
        out_Stall           = !reset && (start || (state_q == WAIT));
        out_Done            = (state_q == DONE);
        out_MisalignedError = !reset && (state_q == IDLE) && access && misaligned;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else if (start) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= in_CtrlMemWrite;
            mem_addr_q  <= in_ALUResult;
            mem_wdata_q <= in_WriteData;
        end else if (state_q == WAIT) begin
            if (mem_ack) begin
                mem_req_q <= 1'b0;
                if (!mem_we_q) mem_data_q <= mem_rdata;
            end else if (expired) begin
                mem_req_q     <= 1'b0;
                timeout_err_q <= 1'b1;
                if (!mem_we_q) mem_data_q <= '0;
            end
        end
    end

    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign out_MemoryData   = mem_data_q;
    assign out_TimeoutError = timeout_err_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Self-checking bench for mem_stage_access_unit with a short timeout depth.
// Expected behaviour comes from a per-access model of stall length, data and flags.
module tb_mem_stage_access_unit;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_Valid;
    logic [AW-1:0] in_ALUResult;
    logic [DW-1:0] in_WriteData;
    logic          in_CtrlMemRead;
    logic          in_CtrlMemWrite;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [DW-1:0] out_MemoryData;
    logic          out_Stall;
    logic          out_Done;
    logic          out_MisalignedError;
    logic          out_TimeoutError;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_data;
    bit            exp_tmo;

    mem_stage_access_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset),
        .in_Valid(in_Valid), .in_ALUResult(in_ALUResult), .in_WriteData(in_WriteData),
        .in_CtrlMemRead(in_CtrlMemRead), .in_CtrlMemWrite(in_CtrlMemWrite),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_MemoryData(out_MemoryData), .out_Stall(out_Stall), .out_Done(out_Done),
        .out_MisalignedError(out_MisalignedError), .out_TimeoutError(out_TimeoutError)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1; in_Valid = 1'b0; in_ALUResult = '0; in_WriteData = '0;
        in_CtrlMemRead = 1'b0; in_CtrlMemWrite = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #2;
        checks++;
        if ({mem_req, mem_we, out_Stall, out_Done, out_MisalignedError, out_TimeoutError} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {mem_req, mem_we, out_Stall, out_Done, out_MisalignedError, out_TimeoutError});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || out_MemoryData !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h data %h required all zero",
                     mem_addr, mem_wdata, out_MemoryData);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_data = '0;
        exp_tmo  = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1. ack_after > T means memory never answers.
    task automatic do_access(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input bit rd, input bit wr, input int ack_after,
                             input logic [DW-1:0] rdata);
        bit is_wr  = wr;
        bit tmo    = (ack_after > T);
        int n_wait = tmo ? T : ack_after;
        int stall_cnt = 0, req_cnt = 0, cyc = 0;
        bit done = 1'b0, bad_hold = 1'b0;
        in_Valid = 1'b1; in_ALUResult = addr; in_WriteData = wdata;
        in_CtrlMemRead = rd; in_CtrlMemWrite = wr; mem_ack = 1'b0;
        while (!done && cyc < T + 10) begin
            @(negedge clk);
            cyc++;
            if (out_Done) begin
                done = 1'b1;
                mem_ack = 1'b0;
                if (!is_wr) exp_data = tmo ? '0 : rdata;
                exp_tmo = exp_tmo | tmo;
                checks++;
                if (cyc !== n_wait + 2) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d required %0d", cyc, n_wait + 2);
                end
                checks++;
                if (stall_cnt !== n_wait + 1) begin
                    errors++;
                    $display("FAIL stall_len: got %0d required %0d", stall_cnt, n_wait + 1);
                end
                checks++;
                if (req_cnt !== n_wait) begin
                    errors++;
                    $display("FAIL req_len: got %0d required %0d", req_cnt, n_wait);
                end
                checks++;
                if (bad_hold) begin
                    errors++;
                    $display("FAIL req_hold: bus changed during request, required addr %h wdata %h we %0d",
                             addr, wdata, is_wr);
                end
                checks++;
                if (out_Stall !== 1'b0 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL done_state: stall %b req %b required 0 0", out_Stall, mem_req);
                end
                checks++;
                if (out_MemoryData !== exp_data) begin
                    errors++;
                    $display("FAIL mem_data: got %h required %h", out_MemoryData, exp_data);
                end
                checks++;
                if (out_TimeoutError !== exp_tmo) begin
                    errors++;
                    $display("FAIL timeout_flag: got %b required %b", out_TimeoutError, exp_tmo);
                end
            end else begin
                if (out_Stall) stall_cnt++;
                if (mem_req) begin
                    req_cnt++;
                    if (mem_addr !== addr || mem_wdata !== wdata || mem_we !== is_wr) bad_hold = 1'b1;
                    mem_ack = (req_cnt == ack_after);
                end else begin
                    mem_ack = 1'b0;
                end
                mem_rdata = mem_ack ? rdata : DW'($urandom);
                // The pipeline register may change underneath a latched access.
                if (cyc >= 2) begin
                    in_ALUResult = AW'($urandom);
                    in_WriteData = DW'($urandom);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no out_Done within %0d cycles, required one", T + 10);
        end
        @(posedge clk);
        #1 in_Valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (out_Done !== 1'b0 || mem_req !== 1'b0 || out_Stall !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done %b req %b stall %b required 0 0 0",
                     out_Done, mem_req, out_Stall);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_misaligned(input logic [AW-1:0] addr, input bit rd, input bit wr);
        in_Valid = 1'b1; in_ALUResult = addr; in_WriteData = DW'($urandom);
        in_CtrlMemRead = rd; in_CtrlMemWrite = wr;
        @(negedge clk);
        checks++;
        if (out_MisalignedError !== 1'b1 || out_Stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: err %b stall %b req %b required 1 0 0",
                     out_MisalignedError, out_Stall, mem_req);
        end
        @(posedge clk);
        #1 in_Valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_MisalignedError !== 1'b0 || mem_req !== 1'b0 || out_Done !== 1'b0 ||
            out_MemoryData !== exp_data) begin
            errors++;
            $display("FAIL misaligned_after: err %b req %b done %b data %h required 0 0 0 %h",
                     out_MisalignedError, mem_req, out_Done, out_MemoryData, exp_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stray_ack(input int n);
        in_Valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_ack = 1'b1; mem_rdata = DW'($urandom);
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || out_Stall !== 1'b0 || out_Done !== 1'b0 ||
                out_MemoryData !== exp_data) begin
                errors++;
                $display("FAIL stray_ack: req %b stall %b done %b data %h required 0 0 0 %h",
                         mem_req, out_Stall, out_Done, out_MemoryData, exp_data);
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        in_Valid = 1'b1; in_ALUResult = 32'h0000_0040; in_WriteData = '0;
        in_CtrlMemRead = 1'b1; in_CtrlMemWrite = 1'b0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_req: got %b required 1", mem_req);
        end
        reset = 1'b1;
        #1;
        exp_data = '0;
        exp_tmo  = 1'b0;
        checks++;
        if ({mem_req, mem_we, out_Stall, out_Done, out_MisalignedError, out_TimeoutError} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || out_MemoryData !== '0) begin
            errors++;
            $display("FAIL rst_mid_wait: flags %b addr %h data %h required all zero",
                     {mem_req, mem_we, out_Stall, out_Done, out_MisalignedError, out_TimeoutError},
                     mem_addr, out_MemoryData);
        end
        in_Valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_Done !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: done %b req %b required 0 0", out_Done, mem_req);
        end
        @(posedge clk);
        #1;
        do_access(32'h0000_0044, 32'h0, 1'b1, 1'b0, 2, 32'h5A5A_A5A5);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            int kind = $urandom_range(0, 9);
            logic [AW-1:0] a = AW'($urandom);
            if (kind < 2) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
                test_misaligned(a, 1'($urandom), 1'b1);
            end else if (kind < 3) begin
                test_stray_ack(1);
            end else begin
                int sel = $urandom_range(0, 2);
                a[1:0] = 2'b00;
                do_access(a, DW'($urandom), sel != 1, sel != 0,
                          $urandom_range(1, T + 2), DW'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        do_access(32'h0000_0010, 32'h0, 1'b1, 1'b0, 1, 32'hCAFE_F00D);
        do_access(32'h0000_0020, 32'h1234_5678, 1'b0, 1'b1, 4, 32'hDEAD_BEEF);
        test_misaligned(32'h0000_0013, 1'b1, 1'b0);
        test_stray_ack(3);
        do_access(32'h0000_0030, 32'h0, 1'b1, 1'b0, T + 5, 32'h1111_2222);
        do_access(32'h0000_0034, 32'h0, 1'b1, 1'b0, 1, 32'h3333_4444);
        test_reset_mid_wait();
        do_access(32'h0000_0050, 32'hAAAA_5555, 1'b1, 1'b1, 3, 32'h7777_8888);
        test_random(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_unit.md
# mem_stage_access_unit

Memory-stage data-access controller between the EX/MEM pipeline register and the MEM/WB pipeline register. It takes the ALU result as address plus the write data and memory controls, runs a req/ack handshake to the data memory, and stalls the pipeline until the access completes. It presents the loaded word to MEM/WB as MemoryData. It also flags misaligned word accesses and memory timeouts.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before abort (≥2).

Ports:
- clk  in  1  single clock, all flops on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- in_Valid  in  1  instruction present in MEM stage.
- in_ALUResult  in  ADDR_WIDTH  access address.
- in_WriteData  in  DATA_WIDTH  store data.
- in_CtrlMemRead  in  1  load.
- in_CtrlMemWrite  in  1  store (priority over read if both set).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  ADDR_WIDTH  latched address.
- mem_wdata  out  DATA_WIDTH  latched store data.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- mem_ack  in  1  completion strobe.
- out_MemoryData  out  DATA_WIDTH  loaded word to MEM/WB.
- out_Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- out_Done  out  1  one-cycle pulse, access complete.
- out_MisalignedError  out  1  one-cycle pulse.
- out_TimeoutError  out  1  sticky until reset.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE, access = in_Valid & (MemRead | MemWrite):
  - aligned (addr[1:0]==0): out_Stall=1 combinationally; latch addr, wdata, we=MemWrite; next WAIT with mem_req=1.
  - misaligned: no request, out_Stall=0, out_MisalignedError=1 this cycle, stay IDLE.
  - no access: out_Stall=0, out_MemoryData holds previous value.
- WAIT: mem_req, mem_we, mem_addr, mem_wdata held stable; out_Stall=1; timeout counter increments each cycle.
  - mem_ack: on a read, capture mem_rdata into out_MemoryData (a write leaves it unchanged); drop mem_req; next DONE.
  - counter reaches TIMEOUT_CYCLES-1 without ack: drop mem_req; on a read, out_MemoryData=0; set out_TimeoutError; next DONE.
- DONE: out_Done=1, out_Stall=0, so the pipeline advances at this edge; next IDLE unconditionally. A new access in the same instruction slot is never restarted.
- mem_ack outside WAIT is ignored.
- Counter clears on entering WAIT.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, out_MemoryData=0, out_Stall=0, out_Done=0, out_MisalignedError=0, out_TimeoutError=0, state=IDLE, counter=0.
- Minimum access (ack in first WAIT cycle):
  - cycle 0: IDLE, stall=1.
  - cycle 1: WAIT, req=1, ack.
  - cycle 2: DONE, data valid.
  - Stall lasts 2 cycles. Each extra ack-wait cycle adds 1 stall cycle.
- Timeout: at most TIMEOUT_CYCLES cycles with mem_req=1.
- Reset asserted mid-WAIT: mem_req drops without a clock edge; the pending access is abandoned with no Done pulse.
- MemRead and MemWrite both set: treated as a write.

## Structure
- Shared package (mem_stage_pkg):
  - state enum {IDLE, WAIT, DONE}.
  - word-alignment mask constant.
  - timeout counter width, $clog2(TIMEOUT_CYCLES).
- Sub-module mem_timeout_counter:
  - inputs clear and enable.
  - output expired at TIMEOUT_CYCLES-1.
- FSM and datapath latches live in the top module.

## Test plan
- Load, addr 0x0000_0010, memory acks 1 cycle after req with 0xCAFE_F00D → out_Stall high 2 cycles, out_Done pulse in cycle 2, out_MemoryData=0xCAFE_F00D.
- Store, addr 0x0000_0020, data 0x1234_5678, ack after 4 cycles → mem_we=1, addr/wdata stable for all 4 cycles, stall 5 cycles, out_MemoryData unchanged.
- Load at addr 0x0000_0013 → no mem_req, out_MisalignedError 1-cycle pulse, out_Stall=0.
- Load with no ack, TIMEOUT_CYCLES=8 → mem_req high exactly 8 cycles, out_MemoryData=0, out_TimeoutError stays 1 until reset.
- Reset raised in the 2nd WAIT cycle → mem_req=0 and all outputs at reset values before the next edge; a following load completes normally.
- Stray mem_ack while IDLE with in_Valid=0 → no state change, out_MemoryData unchanged.
